recv_pkg_segmenter: RTL and testbench

Receive-side segmentation stage that sits directly upstream of the client/server request handler. It takes whole RDMA receive messages (one metadata word plus a 512-bit data stream per message) and cuts each message into fixed-size packages. Each package is emitted as a `recv_meta` word (qpn, msg_num, pkg_num, pkg_total) followed by its data beats, with `last` marking the end of every package. The handler consumes both output channels directly.

---
 rtl/recv_pkg_segmenter_if.sv | 58 +++++
 rtl/recv_pkg_segmenter.sv | 130 +++++++++++++
 tb/tb_recv_pkg_segmenter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/recv_pkg_segmenter_if.sv
// Bundle of the segmenter's handshake channels: whole-message input
// (meta + data stream), package-level output (recv_meta + recv_data),
// and the sticky input-last error flag.
interface recv_pkg_segmenter_if;
   logic         in_meta_valid;
   logic         in_meta_ready;
   logic [15:0]  in_meta_bits_qpn;
   logic [31:0]  in_meta_bits_msg_length;

   logic         in_data_valid;
   logic         in_data_ready;
   logic [511:0] in_data_bits_data;
   logic [63:0]  in_data_bits_keep;
   logic         in_data_bits_last;

   logic         recv_meta_valid;
   logic         recv_meta_ready;
   logic [15:0]  recv_meta_bits_qpn;
   logic [23:0]  recv_meta_bits_msg_num;
   logic [20:0]  recv_meta_bits_pkg_num;
   logic [20:0]  recv_meta_bits_pkg_total;

   logic         recv_data_valid;
   logic         recv_data_ready;
   logic         recv_data_bits_last;
   logic [511:0] recv_data_bits_data;
   logic [63:0]  recv_data_bits_keep;

   logic         err_last;

   // Segmenter side
   modport master (
      input  in_meta_valid, in_meta_bits_qpn, in_meta_bits_msg_length,
      output in_meta_ready,
      input  in_data_valid, in_data_bits_data, in_data_bits_keep, in_data_bits_last,
      output in_data_ready,
      output recv_meta_valid, recv_meta_bits_qpn, recv_meta_bits_msg_num,
             recv_meta_bits_pkg_num, recv_meta_bits_pkg_total,
      input  recv_meta_ready,
      output recv_data_valid, recv_data_bits_last, recv_data_bits_data, recv_data_bits_keep,
      input  recv_data_ready,
      output err_last
   );

   // Environment side (message source + request handler)
   modport slave (
      output in_meta_valid, in_meta_bits_qpn, in_meta_bits_msg_length,
      input  in_meta_ready,
      output in_data_valid, in_data_bits_data, in_data_bits_keep, in_data_bits_last,
      input  in_data_ready,
      input  recv_meta_valid, recv_meta_bits_qpn, recv_meta_bits_msg_num,
             recv_meta_bits_pkg_num, recv_meta_bits_pkg_total,
      output recv_meta_ready,
      input  recv_data_valid, recv_data_bits_last, recv_data_bits_data, recv_data_bits_keep,
      output recv_data_ready,
      input  err_last
   );
endinterface

// File: rtl/recv_pkg_segmenter.sv
// Cuts each RDMA receive message into PKG_BEATS-beat packages. Every package
// is announced by one recv_meta word, then its beats pass straight through
// with an internally generated last. Framing comes from msg_length only;
// input last is merely checked.
module recv_pkg_segmenter #(
   parameter int PKG_BEATS = 64
) (
   input logic                  clock,
   input logic                  reset,
   recv_pkg_segmenter_if.master io
);
   localparam int LG = $clog2(PKG_BEATS);

   typedef enum logic [1:0] {IDLE, META, DATA} state_t;

   state_t      r_state;
   logic        r_in_meta_ready;
   logic        r_meta_valid;
   logic        r_data_en;
   logic        r_err_last;
   logic [15:0] r_qpn;
   logic [23:0] r_msg_num;
   logic [20:0] r_pkg_num;
   logic [20:0] r_pkg_total;
   logic [26:0] r_beats;
   logic [26:0] r_beat_cnt;

   logic [26:0] w_beats;
   logic [20:0] w_pkg_total;
   logic        w_meta_hs;
   logic        w_out_hs;
   logic        w_data_hs;
   logic        w_msg_end;
   logic        w_pkg_end;

   // Message length rounded up to whole 64-byte beats, then to whole packages
   assign w_beats     = {1'b0, io.in_meta_bits_msg_length[31:6]} + 27'(|io.in_meta_bits_msg_length[5:0]);
   assign w_pkg_total = 21'(w_beats >> LG) + 21'(|w_beats[LG-1:0]);

   assign w_meta_hs = r_in_meta_ready & io.in_meta_valid;
   assign w_out_hs  = r_meta_valid & io.recv_meta_ready;
   assign w_data_hs = r_data_en & io.in_data_valid & io.recv_data_ready;

   // Packages are beat-aligned within the message, so the in-package index is
   // just the low bits of the message beat counter.
   assign w_msg_end = (r_beat_cnt == r_beats - 27'd1);
   assign w_pkg_end = (r_beat_cnt[LG-1:0] == LG'(PKG_BEATS - 1)) | w_msg_end;

   assign io.in_meta_ready            = r_in_meta_ready;
   assign io.recv_meta_valid          = r_meta_valid;
   assign io.recv_meta_bits_qpn       = r_qpn;
   assign io.recv_meta_bits_msg_num   = r_msg_num;
   assign io.recv_meta_bits_pkg_num   = r_pkg_num;
   assign io.recv_meta_bits_pkg_total = r_pkg_total;
   assign io.err_last                 = r_err_last;

   // Data path is a zero-latency pass-through gated by the DATA state
   assign io.recv_data_valid     = r_data_en & io.in_data_valid;
   assign io.in_data_ready       = r_data_en & io.recv_data_ready;
   assign io.recv_data_bits_data = io.in_data_bits_data;
   assign io.recv_data_bits_keep = io.in_data_bits_keep;
   assign io.recv_data_bits_last = r_data_en & w_pkg_end;

   // Segmentation FSM with registered handshake outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state         <= IDLE;
         r_in_meta_ready <= 1'b1;
         r_meta_valid    <= 1'b0;
         r_data_en       <= 1'b0;
         r_err_last      <= 1'b0;
         r_qpn           <= '0;
         r_msg_num       <= '0;
         r_pkg_num       <= '0;
         r_pkg_total     <= '0;
         r_beats         <= '0;
         r_beat_cnt      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_meta_hs) begin
                  r_qpn       <= io.in_meta_bits_qpn;
                  r_beats     <= w_beats;
                  r_pkg_total <= w_pkg_total;
                  r_pkg_num   <= '0;
                  r_beat_cnt  <= '0;
                  // Zero-length messages are swallowed without output
                  if (io.in_meta_bits_msg_length != 32'd0) begin
                     r_state         <= META;
                     r_in_meta_ready <= 1'b0;
                     r_meta_valid    <= 1'b1;
                  end
               end
            end
            META: begin
               if (w_out_hs) begin
                  r_state      <= DATA;
                  r_meta_valid <= 1'b0;
                  r_data_en    <= 1'b1;
               end
            end
            DATA: begin
               if (w_data_hs) begin
                  r_beat_cnt <= r_beat_cnt + 27'd1;
                  if (io.in_data_bits_last != w_msg_end)
                     r_err_last <= 1'b1;
                  if (w_pkg_end) begin
                     r_data_en <= 1'b0;
                     if (!w_msg_end) begin
                        r_pkg_num    <= r_pkg_num + 21'd1;
                        r_state      <= META;
                        r_meta_valid <= 1'b1;
                     end else begin
                        r_msg_num       <= r_msg_num + 24'd1;
                        r_state         <= IDLE;
                        r_in_meta_ready <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               r_state         <= IDLE;
               r_in_meta_ready <= 1'b1;
               r_meta_valid    <= 1'b0;
               r_data_en       <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_recv_pkg_segmenter.sv
// Directed bench for recv_pkg_segmenter (PKG_BEATS=64). Each message is driven
// beat by beat; expected metas, per-beat last, data and the error flag are
// derived from msg_length and the package size.
module tb_recv_pkg_segmenter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   recv_pkg_segmenter_if io();

   recv_pkg_segmenter #(.PKG_BEATS(64)) dut (
      .clock (clock),
      .reset (reset),
      .io    (io)
   );

   int checks   = 0;
   int failures = 0;
   int msg_exp  = 0;
   bit err_exp  = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One package: meta (optionally stalled), then nb beats starting at message beat base
   task automatic do_pkg(input int qpn, input int pn, input int ptot, input int base,
                         input int nb, input int total, input int bad, input bit toggle,
                         input int stall);
      int g;
      bit hs;
      io.in_data_valid   = 1'b1;
      io.recv_meta_ready = 1'b0;
      io.recv_data_ready = 1'b1;
      #1;
      chk("meta_valid", 64'(io.recv_meta_valid), 64'd1);
      chk("bubble_no_data", 64'(io.recv_data_valid), 64'd0);
      chk("no_early_data", 64'(io.in_data_ready), 64'd0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clock); #1;
         chk("stall_meta_valid", 64'(io.recv_meta_valid), 64'd1);
         chk("stall_qpn", 64'(io.recv_meta_bits_qpn), 64'(qpn));
         chk("stall_in_data_ready", 64'(io.in_data_ready), 64'd0);
      end
      chk("meta_qpn", 64'(io.recv_meta_bits_qpn), 64'(qpn));
      chk("meta_msg_num", 64'(io.recv_meta_bits_msg_num), 64'(msg_exp));
      chk("meta_pkg_num", 64'(io.recv_meta_bits_pkg_num), 64'(pn));
      chk("meta_pkg_total", 64'(io.recv_meta_bits_pkg_total), 64'(ptot));
      io.recv_meta_ready = 1'b1;
      @(posedge clock); #1;
      io.recv_meta_ready = 1'b0;
      io.recv_data_ready = 1'b0;
      for (int b = 0; b < nb; b++) begin
         g  = base + b;
         hs = 1'b0;
         io.in_data_bits_data = {~64'(g), 384'd0, 64'(g)};
         io.in_data_bits_keep = ~64'(g);
         io.in_data_bits_last = (bad >= 0) ? (g == bad) : (g == total - 1);
         while (!hs) begin
            io.recv_data_ready = toggle ? ~io.recv_data_ready : 1'b1;
            #1;
            if (io.recv_data_ready) begin
               chk("data_valid", 64'(io.recv_data_valid), 64'd1);
               chk("in_data_ready", 64'(io.in_data_ready), 64'd1);
               chk("in_meta_ready_busy", 64'(io.in_meta_ready), 64'd0);
               chk("data_lo", io.recv_data_bits_data[63:0], 64'(g));
               chk("data_hi", io.recv_data_bits_data[511:448], ~64'(g));
               chk("keep", io.recv_data_bits_keep, ~64'(g));
               chk("last", 64'(io.recv_data_bits_last), 64'((g % 64 == 63) || (g == total - 1)));
               hs = 1'b1;
            end else begin
               chk("bp_in_data_ready", 64'(io.in_data_ready), 64'd0);
            end
            @(posedge clock); #1;
         end
         if (g == bad) err_exp = 1'b1;
         chk("err_last", 64'(io.err_last), 64'(err_exp));
      end
      io.in_data_valid = 1'b0;
   endtask

   task automatic send_meta(input int qpn, input int len);
      io.in_meta_valid           = 1'b1;
      io.in_meta_bits_qpn        = 16'(qpn);
      io.in_meta_bits_msg_length = 32'(len);
      #1;
      chk("in_meta_ready", 64'(io.in_meta_ready), 64'd1);
      @(posedge clock); #1;
      io.in_meta_valid = 1'b0;
   endtask

   task automatic send_msg(input int qpn, input int len, input int bad, input bit toggle,
                           input int stall);
      int total, pkgs, nb;
      send_meta(qpn, len);
      if (len == 0) begin
         #1;
         chk("len0_no_meta", 64'(io.recv_meta_valid), 64'd0);
         chk("len0_idle", 64'(io.in_meta_ready), 64'd1);
         return;
      end
      total = (len + 63) / 64;
      pkgs  = (total + 63) / 64;
      for (int p = 0; p < pkgs; p++) begin
         nb = (total - 64 * p > 64) ? 64 : total - 64 * p;
         do_pkg(qpn, p, pkgs, 64 * p, nb, total, bad, toggle, (p == 0) ? stall : 0);
      end
      io.in_data_valid   = 1'b1;
      io.recv_data_ready = 1'b1;
      #1;
      chk("end_idle_ready", 64'(io.in_meta_ready), 64'd1);
      chk("end_meta_valid", 64'(io.recv_meta_valid), 64'd0);
      chk("end_data_valid", 64'(io.recv_data_valid), 64'd0);
      io.in_data_valid = 1'b0;
      msg_exp = (msg_exp + 1) & 24'hFFFFFF;
   endtask

   initial begin
      io.in_meta_valid           = 1'b0;
      io.in_meta_bits_qpn        = '0;
      io.in_meta_bits_msg_length = '0;
      io.in_data_valid           = 1'b1;
      io.in_data_bits_data       = '0;
      io.in_data_bits_keep       = '0;
      io.in_data_bits_last       = 1'b0;
      io.recv_meta_ready         = 1'b0;
      io.recv_data_ready         = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock); #1;
      chk("rst_in_meta_ready", 64'(io.in_meta_ready), 64'd1);
      chk("rst_meta_valid", 64'(io.recv_meta_valid), 64'd0);
      chk("rst_data_valid", 64'(io.recv_data_valid), 64'd0);
      chk("rst_in_data_ready", 64'(io.in_data_ready), 64'd0);
      chk("rst_err_last", 64'(io.err_last), 64'd0);
      chk("rst_meta_bits", 64'({io.recv_meta_bits_qpn, io.recv_meta_bits_msg_num}), 64'd0);
      chk("rst_pkg_bits", 64'({io.recv_meta_bits_pkg_num, io.recv_meta_bits_pkg_total}), 64'd0);
      io.in_data_valid = 1'b0;

      send_msg(2, 64, -1, 1'b0, 0);
      send_msg(5, 8193, -1, 1'b0, 0);
      send_msg(6, 0, -1, 1'b0, 0);
      send_msg(6, 128, -1, 1'b0, 0);
      send_msg(7, 4096, -1, 1'b1, 20);
      send_msg(8, 512, 2, 1'b0, 0);

      // Abandon a long message after 10 beats
      send_meta(9, 8192);
      do_pkg(9, 0, 2, 0, 10, 128, -1, 1'b0, 0);
      io.in_data_valid   = 1'b1;
      io.recv_data_ready = 1'b1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("midrst_data_valid", 64'(io.recv_data_valid), 64'd0);
      chk("midrst_meta_valid", 64'(io.recv_meta_valid), 64'd0);
      chk("midrst_in_data_ready", 64'(io.in_data_ready), 64'd0);
      chk("midrst_err_last", 64'(io.err_last), 64'd0);
      reset            = 1'b0;
      io.in_data_valid = 1'b0;
      msg_exp          = 0;
      err_exp          = 1'b0;
      @(posedge clock); #1;
      send_msg(3, 64, -1, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
